// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Four-digit multiplexed seven-segment driver with a sequential binary-to-BCD
//   converter (double dabble, one bit per clock) and a display blink option.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit is lit
//   BLINK_DIV   : clk cycles per blink-phase toggle
// Ports
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   value    : 14-bit unsigned number, captured on an accepted load
//   load     : capture request, honoured only while busy is low
//   busy     : conversion in progress (14 cycles)
//   dp       : decimal-point enables, bit i for digit i
//   blink_en : blank the display during the off blink phase
//   seg      : active-low cathodes {DP,g,f,e,d,c,b,a}
//   an       : active-low anodes, an[0] = ones digit
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    input  logic [3:0]  dp,
    input  logic        blink_en,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t         state;
    logic [13:0]    bin_sr;     // remaining binary bits, MSB shifted out first
    logic [15:0]    bcd_work;   // conversion scratch, never shown directly
    logic [15:0]    bcd_disp;   // digits currently on the display
    logic [3:0]     step;
    logic [RW-1:0]  ref_cnt;
    logic [BW-1:0]  blk_cnt;
    logic [1:0]     idx;
    logic           phase_on;

    logic [15:0]    adj;
    logic [15:0]    bcd_shift;
    logic [3:0]     digit;
    logic [6:0]     seg7;
    logic           blank;
    logic [7:0]     seg_next;
    logic [3:0]     an_next;

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
    always_comb begin
        adj = bcd_work;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
        bcd_shift = {adj[14:0], bin_sr[13]};
    end

    always_comb begin
        case (idx)
            2'd0:    digit = bcd_disp[3:0];
            2'd1:    digit = bcd_disp[7:4];
            2'd2:    digit = bcd_disp[11:8];
            default: digit = bcd_disp[15:12];
        endcase
        case (digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
        blank    = blink_en & ~phase_on;
        seg_next = blank ? 8'hFF : {~dp[idx], seg7};
        an_next  = blank ? 4'hF  : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bin_sr   <= '0;
            bcd_work <= '0;
            bcd_disp <= '0;
            step     <= '0;
            ref_cnt  <= '0;
            blk_cnt  <= '0;
            idx      <= '0;
            phase_on <= 1'b1;
            seg      <= '1;
            an       <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;

            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            if (blk_cnt == BLK_LAST) begin
                blk_cnt  <= '0;
                phase_on <= ~phase_on;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr   <= (value > 14'd9999) ? 14'd9999 : value;
                        bcd_work <= '0;
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd_work <= bcd_shift;
                    bin_sr   <= {bin_sr[12:0], 1'b0};
                    step     <= step + 4'd1;
                    if (step == 4'd13) begin
                        bcd_disp <= bcd_shift;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        busy;
    logic [3:0]  dp = '0;
    logic        blink_en = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail = 0;

    seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .busy(busy),
        .dp(dp), .blink_en(blink_en), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour in decimal terms: digits come from division, not BCD shifting.
    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int pow10 [4] = '{1, 10, 100, 1000};

    logic [12:0] exp_q [$];
    int   m_disp, m_pend, m_left, m_rcnt, m_bcnt, m_idx, d;
    bit   m_busy, m_phase, blank;
    logic [3:0] e_an;
    logic [7:0] e_seg;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_disp = 0; m_rcnt = 0; m_idx = 0;
            m_bcnt = 0; m_phase = 1; m_left = 0;
            e_an = 4'hF; e_seg = 8'hFF;
        end else begin
            blank = blink_en && !m_phase;
            d = (m_disp / pow10[m_idx]) % 10;
            e_an  = blank ? 4'hF : ~(4'b0001 << m_idx);
            e_seg = blank ? 8'hFF : (segtab[d] & (dp[m_idx] ? 8'h7F : 8'hFF));
            if (m_rcnt == 3) begin m_rcnt = 0; m_idx = (m_idx + 1) % 4; end
            else m_rcnt++;
            if (m_bcnt == 15) begin m_bcnt = 0; m_phase = !m_phase; end
            else m_bcnt++;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_disp = m_pend; end
            end else if (load) begin
                m_pend = (value > 9999) ? 9999 : int'(value);
                m_busy = 1;
                m_left = 14;
            end
        end
        exp_q.push_back({m_busy, e_an, e_seg});
    end

    int busy_run = 0;
    logic [12:0] e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy", 32'(busy), 32'(e[12]));
            check("an", 32'(an), 32'(e[11:8]));
            check("seg", 32'(seg), 32'(e[7:0]));
            check("one_anode", 32'($countones(~an) <= 1), 32'd1);
            if (!rst_n) busy_run = 0;
            else if (busy === 1'b1) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", busy_run, 32'd14);
                busy_run = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        tick(1);
        load  = 1'b0;
    endtask

    initial begin
        bit found;
        tick(3);
        rst_n = 1'b1;
        tick(20);                       // plain scan of 0000

        do_load(14'd1234);
        tick(3);
        do_load(14'd5678);              // ignored: converter busy
        tick(20);
        dp = 4'b0100;
        tick(20);
        dp = 4'b0000;

        do_load(14'd12000);             // saturates to 9999
        tick(30);

        value = 14'd42;                 // held load: back-to-back acceptance
        load  = 1'b1;
        tick(40);
        load  = 1'b0;
        tick(5);

        blink_en = 1'b1;
        tick(40);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (!m_phase) found = 1;
            else tick(1);
        end
        check("blink_off_found", 32'(found), 32'd1);
        tick(3);
        blink_en = 1'b0;                // scanning resumes next cycle
        tick(10);

        do_load(14'd4321);
        tick(6);
        rst_n = 1'b0;                   // abort mid-conversion
        tick(2);
        rst_n = 1'b1;
        tick(20);

        do_load(14'd0);
        tick(24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is lit (1 kHz at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 50000000, meaning clk cycles per blink-phase toggle.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port value  input  14  unsigned binary number to display.
REQ-006 SHALL have port load  input  1  request to capture value.
REQ-007 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-008 SHALL have port dp  input  4  decimal-point enables, bit i for digit i.
REQ-009 SHALL have port blink_en  input  1  blanks the display during the off blink phase.
REQ-010 SHALL have port seg  output  8  active-low cathodes: seg[6:0]={g,f,e,d,c,b,a}, seg[7]=DP.
REQ-011 SHALL have port an  output  4  active-low anodes; an[0]=ones digit, an[3]=thousands.

Function
REQ-012 SHALL accept load only when busy=0; load while busy=1 SHALL be ignored.
REQ-013 On acceptance, SHALL capture value, saturated to 9999 if value>9999.
REQ-014 SHALL assert busy on the cycle after acceptance and hold it for exactly 14 cycles.
REQ-015 SHALL convert with sequential shift-add-3 (double dabble), one bit per cycle.
REQ-016 SHALL update the 4-digit BCD display register on the cycle busy falls.
REQ-017 SHALL keep showing the previous digits throughout a conversion, with no partial digits visible.
REQ-018 A new load SHALL be accepted on the same cycle busy reads 0.
REQ-019 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap, digit index SHALL advance 0->1->2->3->0.
REQ-020 an SHALL be registered: an[idx]=0, other anodes=1.
REQ-021 seg SHALL be registered from the BCD digit at idx: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, DP off).
REQ-022 When dp[idx]=1, seg[7] SHALL be 0.
REQ-023 Blink counter SHALL count 0..BLINK_DIV-1 and wrap; on each wrap, the blink phase SHALL toggle.
REQ-024 The blink counter SHALL run regardless of blink_en.
REQ-025 When blink_en=1 and phase=off, an SHALL be 4'b1111 and seg SHALL be 8'hFF.
REQ-026 Scanning SHALL continue internally while blanked.
REQ-027 Leading zeros SHALL be displayed; there is no zero suppression.
REQ-028 Only one anode SHALL ever be low in any cycle.

Reset
REQ-029 While rst_n=0 at a clock edge, busy SHALL be 0.
REQ-030 While rst_n=0, the BCD register, refresh counter, blink counter and idx SHALL be 0, and the blink phase SHALL be on.
REQ-031 While rst_n=0, an SHALL be 4'b1111 and seg SHALL be 8'hFF.
REQ-032 First cycle after release SHALL show an=4'b1110, seg=8'hC0.
REQ-033 Reset during conversion SHALL abort it, leaving the BCD register at 0000 and dropping the pending value.

Verification
REQ-034 Bench SHALL use REFRESH_DIV=4 and BLINK_DIV=16 and cover the following scenarios.
REQ-035 Reset release, then scan: an sequence SHALL be 1110,1101,1011,0111,1110 with each step held 4 cycles; seg SHALL be C0 throughout.
REQ-036 load with value=1234: busy SHALL be high for 14 cycles, then digits SHALL read 4,3,2,1 (seg 99,B0,A4,F9) for an 1110..0111.
REQ-037 load with value=12000 SHALL display 9999 (seg 90 on all digits).
REQ-038 load with value=5678 while busy: the request SHALL be ignored and the earlier result SHALL be shown; dp=4'b0100 SHALL give seg[7]=0 only while an=1011.
REQ-039 blink_en=1: an SHALL be 1111 and seg FF for 16 cycles, then scan for 16 cycles, repeating; blink_en=0 mid-off-phase SHALL restore scanning the next cycle.
REQ-040 rst_n=0 at cycle 7 of a conversion of 4321: busy SHALL be 0 and display SHALL be 0000 after release.
